pipe_stage_chain: RTL and testbench
===================================

PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 Parameter DATA_W, default 32, width of the payload carried per stage.
REQ-002 Parameter DEPTH, default 3, number of register stages (legal 1..8).
REQ-003 Parameter MODE, default 1; 0 = LOCKSTEP (whole chain stalls together), 1 = ELASTIC (bubbles collapse).
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 RST  in  1  reset, synchronous and active-high.
REQ-006 in_valid  in  1  upstream holds a payload.
REQ-007 in_data  in  DATA_W  upstream payload.
REQ-008 in_ready  out  1  stage 0 accepts this cycle.
REQ-009 out_valid  out  1  last stage holds a payload.
REQ-010 out_data  out  DATA_W  last-stage payload.
REQ-011 out_ready  in  1  downstream consumes this cycle.
REQ-012 flush  in  1  kill every stage.
REQ-013 kill_mask  in  DEPTH  per-stage kill; bit i squashes stage i (younger-instruction squash).
REQ-014 occupancy  out  $clog2(DEPTH+1)  count of valid stages.
REQ-015 stall_cycles  out  16  saturating count of cycles with out_valid && !out_ready.

Function
REQ-016 Each stage i SHALL hold valid[i] and data[i]; stage 0 is input side and stage DEPTH-1 drives out_valid/out_data directly (no combinational in->out path).
REQ-017 Transfer out SHALL occur when out_valid && out_ready.
REQ-018 Transfer in SHALL occur when in_valid && in_ready.
REQ-019 LOCKSTEP: advance = !valid[DEPTH-1] || out_ready; all stages shift together on advance, none change otherwise; in_ready = advance.
REQ-020 ELASTIC: stage DEPTH-1 moves when out_ready or empty; stage i<DEPTH-1 moves when stage i+1 is empty or moving; in_ready = stage 0 empty or moving.
REQ-021 A moving stage with an invalid predecessor SHALL become invalid (bubble); data of invalid stages is don't-care but SHALL NOT toggle when valid is 0.
REQ-022 With out_ready held 1, latency in->out SHALL be exactly DEPTH cycles, throughput one per cycle, both modes.
REQ-023 flush SHALL clear all valid bits at the next edge, override any transfer in that cycle, and the incoming beat SHALL be dropped; in_ready SHALL read 0 while flush is 1.
REQ-024 kill_mask[i] SHALL clear the valid bit that would land in stage i at the next edge (i.e. applied after the shift); kill and flush never block out-transfer of the current out_valid beat.
REQ-025 occupancy SHALL equal popcount of valid bits after each edge; never exceeds DEPTH.
REQ-026 stall_cycles SHALL increment by 1 each cycle out_valid && !out_ready, saturating at 0xFFFF, unaffected by flush.
REQ-027 Simultaneous in and out transfer on a full chain SHALL keep occupancy at DEPTH (no lost or duplicated beat).

Reset
REQ-028 RST asserted at an edge SHALL clear all valid bits, occupancy to 0, stall_cycles to 0; out_valid=0 and in_ready=1 in the cycle after.
REQ-029 data registers SHALL NOT require reset.
REQ-030 RST mid-operation SHALL discard all in-flight beats regardless of flush/kill_mask/out_ready.

Structure
REQ-031 Mode encoding (pipe_mode_t: PIPE_LOCKSTEP=0, PIPE_ELASTIC=1) and the 16-bit stall counter width constant SHALL live in cpu_types_pkg.
REQ-032 One sub-module pipe_stage_reg (single valid+data register with move/kill inputs) SHALL be instantiated DEPTH times via generate.
REQ-033 Block SHALL be replacement-compatible with existing fixed pipeline latches when DEPTH=1, MODE=0.

Verification
REQ-034 DEPTH=3 both modes, in_valid=1, data 1,2,3..., out_ready=1 -> out_data 1 appears cycle 3, then 2,3,... each cycle, occupancy 3.
REQ-035 ELASTIC, DEPTH=3, single beat 0xA then out_ready=0 for 5 cycles -> 0xA parks in stage 2, next two beats fill stages 1,0, in_ready falls after 2 further accepts, stall_cycles=5.
REQ-036 LOCKSTEP, same stimulus -> in_ready=0 from first stall cycle, occupancy frozen at 1.
REQ-037 Full chain, flush=1 with in_valid=1 -> next cycle occupancy 0, out_valid 0, beat dropped.
REQ-038 Full chain, out_ready=1, kill_mask=3'b010 -> oldest beat exits, beat from old stage 0 killed, occupancy 2.
REQ-039 RST pulse with full chain and stall_cycles=0xFFFF -> occupancy 0, stall_cycles 0, in_ready 1.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: chain stall policy encoding and stall counter sizing.
package cpu_types_pkg;

    typedef enum logic {
        PIPE_LOCKSTEP = 1'b0,
        PIPE_ELASTIC  = 1'b1
    } pipe_mode_t;

    localparam int STALL_W = 16;
    localparam logic [STALL_W-1:0] STALL_MAX = '1;

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline slot: valid+payload register, 1-cycle latency; holds when move is low.
// kill clears whatever valid would land here; payload only loads on a live incoming beat.
module pipe_stage_reg #(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              move,
    input  logic              kill,
    input  logic              d_valid,
    input  logic [DATA_W-1:0] d_data,
    output logic              q_valid,
    output logic [DATA_W-1:0] q_data
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            q_valid <= 1'b0;
        end else begin
            q_valid <= (move ? d_valid : q_valid) & ~kill;
        end
    end

    // Payload is left unreset and frozen under bubbles to avoid needless toggling.
    always_ff @(posedge CLK) begin
        if (move && d_valid && !kill) begin
            q_data <= d_data;
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// DEPTH-stage registered pipeline, in->out latency DEPTH cycles, one beat per cycle.
// Backpressure: LOCKSTEP stalls all stages together; ELASTIC lets bubbles collapse.
module pipe_stage_chain
    import cpu_types_pkg::*;
#(
    parameter int         DATA_W = 32,
    parameter int         DEPTH  = 3,
    parameter pipe_mode_t MODE   = PIPE_ELASTIC
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    input  logic                         out_ready,
    input  logic                         flush,
    input  logic [DEPTH-1:0]             kill_mask,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [STALL_W-1:0]           stall_cycles
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]  vld;
    logic [DATA_W-1:0] dat [DEPTH];
    logic [DEPTH-1:0]  mv;

    // A stage may move if any stage at or beyond it is empty, or the sink drains.
    always_comb begin
        logic hole;
        hole = out_ready;
        mv   = '0;
        if (MODE == PIPE_LOCKSTEP) begin
            mv = {DEPTH{!vld[DEPTH-1] || out_ready}};
        end else begin
            for (int i = DEPTH-1; i >= 0; i--) begin
                hole  = hole | !vld[i];
                mv[i] = hole;
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic              prev_vld;
        logic [DATA_W-1:0] prev_dat;

        if (i == 0) begin : g_head
            assign prev_vld = in_valid & ~flush;
            assign prev_dat = in_data;
        end else begin : g_body
            assign prev_vld = vld[i-1];
            assign prev_dat = dat[i-1];
        end

        pipe_stage_reg #(
            .DATA_W (DATA_W)
        ) u_reg (
            .CLK     (CLK),
            .RST     (RST),
            .move    (mv[i]),
            .kill    (flush | kill_mask[i]),
            .d_valid (prev_vld),
            .d_data  (prev_dat),
            .q_valid (vld[i]),
            .q_data  (dat[i])
        );
    end

    assign in_ready  = mv[0] & ~flush;
    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(vld[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cycles <= '0;
        end else if (out_valid && !out_ready && stall_cycles != STALL_MAX) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench: ELASTIC and LOCKSTEP DEPTH=3 chains driven by the same stimulus.
module tb_pipe_stage_chain;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        flush;
    logic [2:0]  kill_mask;

    logic        e_in_ready, e_out_valid;
    logic [31:0] e_out_data;
    logic [1:0]  e_occ;
    logic [15:0] e_stall;

    logic        l_in_ready, l_out_valid;
    logic [31:0] l_out_data;
    logic [1:0]  l_occ;
    logic [15:0] l_stall;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    pipe_stage_chain #(.DATA_W(32), .DEPTH(3), .MODE(PIPE_ELASTIC)) dut_e (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data), .in_ready(e_in_ready),
        .out_valid(e_out_valid), .out_data(e_out_data), .out_ready(out_ready), .flush(flush),
        .kill_mask(kill_mask), .occupancy(e_occ), .stall_cycles(e_stall)
    );

    pipe_stage_chain #(.DATA_W(32), .DEPTH(3), .MODE(PIPE_LOCKSTEP)) dut_l (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data), .in_ready(l_in_ready),
        .out_valid(l_out_valid), .out_data(l_out_data), .out_ready(out_ready), .flush(flush),
        .kill_mask(kill_mask), .occupancy(l_occ), .stall_cycles(l_stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        flush = 1'b0; kill_mask = '0;
        tick(); tick();
        check("rst_occ_e",   32'(e_occ),       32'd0);
        check("rst_occ_l",   32'(l_occ),       32'd0);
        check("rst_oval_e",  32'(e_out_valid), 32'd0);
        check("rst_oval_l",  32'(l_out_valid), 32'd0);
        check("rst_stall_e", 32'(e_stall),     32'd0);
        check("rst_stall_l", 32'(l_stall),     32'd0);
        check("rst_irdy_e",  32'(e_in_ready),  32'd1);
        check("rst_irdy_l",  32'(l_in_ready),  32'd1);
        RST = 1'b0;

        // Streaming: beat k enters at edge k and leaves stage 2 after edge k+2.
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            in_data = 32'(k);
            tick();
            if (k >= 3) begin
                check("stream_data_e", e_out_data, 32'(k-2));
                check("stream_data_l", l_out_data, 32'(k-2));
                check("stream_occ_e",  32'(e_occ), 32'd3);
                check("stream_occ_l",  32'(l_occ), 32'd3);
            end else begin
                check("fill_occ_e", 32'(e_occ), 32'(k));
                check("fill_occ_l", 32'(l_occ), 32'(k));
            end
        end
        in_valid = 1'b0;
        repeat (3) tick();
        check("drain_occ_e", 32'(e_occ), 32'd0);
        check("drain_occ_l", 32'(l_occ), 32'd0);

        // Single beat 0xA travels to stage 2, then the sink stalls for 5 cycles.
        in_valid = 1'b1; in_data = 32'hA; out_ready = 1'b0;
        #1;
        check("a_irdy_e", 32'(e_in_ready), 32'd1);
        check("a_irdy_l", 32'(l_in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        tick(); tick();
        check("park_oval_e", 32'(e_out_valid), 32'd1);
        check("park_data_e", e_out_data,       32'hA);
        check("park_occ_l",  32'(l_occ),       32'd1);
        check("park_data_l", l_out_data,       32'hA);

        in_valid = 1'b1; in_data = 32'hB;
        #1;
        check("s1_irdy_e", 32'(e_in_ready), 32'd1);
        check("s1_irdy_l", 32'(l_in_ready), 32'd0);
        tick();
        check("s1_occ_e", 32'(e_occ), 32'd2);
        check("s1_occ_l", 32'(l_occ), 32'd1);
        in_data = 32'hC;
        #1;
        check("s2_irdy_e", 32'(e_in_ready), 32'd1);
        tick();
        check("s2_occ_e", 32'(e_occ), 32'd3);
        in_data = 32'hD;
        #1;
        check("s3_irdy_e", 32'(e_in_ready), 32'd0);
        check("s3_irdy_l", 32'(l_in_ready), 32'd0);
        tick(); tick(); tick();
        check("stall5_e",     32'(e_stall), 32'd5);
        check("stall5_l",     32'(l_stall), 32'd5);
        check("stall_occ_e",  32'(e_occ),   32'd3);
        check("stall_occ_l",  32'(l_occ),   32'd1);
        check("stall_data_e", e_out_data,   32'hA);
        check("stall_data_l", l_out_data,   32'hA);

        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("rel_data_e", e_out_data,       32'hB);
        check("rel_occ_e",  32'(e_occ),       32'd2);
        check("rel_oval_l", 32'(l_out_valid), 32'd0);
        check("rel_occ_l",  32'(l_occ),       32'd0);
        tick();
        check("rel2_data_e", e_out_data, 32'hC);
        tick();
        check("rel3_occ_e",   32'(e_occ),   32'd0);
        check("rel3_stall_e", 32'(e_stall), 32'd5);

        // Per-stage kill on a full, advancing chain.
        in_valid = 1'b1;
        in_data = 32'h11; tick();
        in_data = 32'h22; tick();
        in_data = 32'h33; tick();
        check("full_data_e", e_out_data, 32'h11);
        check("full_data_l", l_out_data, 32'h11);
        kill_mask = 3'b010; in_data = 32'h44;
        tick();
        kill_mask = 3'b000;
        check("kill_occ_e",  32'(e_occ),       32'd2);
        check("kill_occ_l",  32'(l_occ),       32'd2);
        check("kill_data_e", e_out_data,       32'h22);
        check("kill_data_l", l_out_data,       32'h22);
        check("kill_oval_e", 32'(e_out_valid), 32'd1);
        in_data = 32'h55;
        tick();
        check("bubble_oval_e", 32'(e_out_valid), 32'd0);
        check("bubble_oval_l", 32'(l_out_valid), 32'd0);
        check("bubble_occ_e",  32'(e_occ),       32'd2);
        in_data = 32'h66;
        tick();
        check("refill_data_e", e_out_data, 32'h44);
        check("refill_occ_l",  32'(l_occ), 32'd3);
        in_data = 32'h77;
        tick();
        check("inout_occ_e",  32'(e_occ),  32'd3);
        check("inout_occ_l",  32'(l_occ),  32'd3);
        check("inout_data_e", e_out_data,  32'h55);
        check("inout_data_l", l_out_data,  32'h55);

        // Flush of a full chain drops the offered beat too.
        flush = 1'b1; in_data = 32'h88;
        #1;
        check("flush_irdy_e", 32'(e_in_ready), 32'd0);
        check("flush_irdy_l", 32'(l_in_ready), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_occ_e",   32'(e_occ),       32'd0);
        check("flush_occ_l",   32'(l_occ),       32'd0);
        check("flush_oval_e",  32'(e_out_valid), 32'd0);
        check("flush_stall_e", 32'(e_stall),     32'd5);
        repeat (3) tick();
        check("dropped_oval_e", 32'(e_out_valid), 32'd0);
        check("dropped_oval_l", 32'(l_out_valid), 32'd0);

        // Saturate the stall counter on a full chain, then reset mid-operation.
        in_valid = 1'b1; in_data = 32'h99; out_ready = 1'b0;
        repeat (3) tick();
        check("sat_fill_occ_e", 32'(e_occ), 32'd3);
        check("sat_fill_occ_l", 32'(l_occ), 32'd3);
        repeat (65535) tick();
        check("sat_stall_e", 32'(e_stall), 32'hFFFF);
        check("sat_stall_l", 32'(l_stall), 32'hFFFF);
        RST = 1'b1;
        tick();
        check("mrst_occ_e",   32'(e_occ),       32'd0);
        check("mrst_occ_l",   32'(l_occ),       32'd0);
        check("mrst_stall_e", 32'(e_stall),     32'd0);
        check("mrst_stall_l", 32'(l_stall),     32'd0);
        check("mrst_irdy_e",  32'(e_in_ready),  32'd1);
        check("mrst_irdy_l",  32'(l_in_ready),  32'd1);
        check("mrst_oval_e",  32'(e_out_valid), 32'd0);
        RST = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
